trap_controller: RTL and testbench

- Consumes the decode-stage exception outputs (invalid_inst, ecall, faulting_inst) and the decoded mret indication.
- Sequences the machine-mode trap and return flow:
  - writes mcause/mepc/mtval into the CSR file;
  - pulses a pipeline flush;
  - issues a PC redirect to mtvec or mepc;
  - holds a drain stall until in-flight work settles.
- Sits between the decode stage, the CSR file and the fetch PC mux.

---
 rtl/trap_controller.sv | 168 ++++++++++++++++
 tb/tb_trap_controller.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_controller.sv
// trap_controller: machine-mode trap / MRET sequencer.
// Samples decode-stage exceptions in IDLE. For a trap it writes mcause/mepc/mtval
// into the CSR file. It pulses a pipeline flush and redirects fetch to mtvec
// (trap) or mepc (MRET). It then holds a drain stall for DRAIN_CYCLES cycles
// after the redirect is accepted. Every output comes straight from a flop.
module trap_controller #(
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [31:0] id_pc,
    input  logic        invalid_inst,
    input  logic        ecall,
    input  logic        mret,
    input  logic [31:0] faulting_inst,
    input  logic        flush_in,
    input  logic        stall_mmu,
    input  logic [31:0] mtvec_in,
    input  logic [31:0] mepc_in,
    input  logic        redirect_ready,
    output logic        csr_we,
    output logic [31:0] mcause_out,
    output logic [31:0] mepc_out,
    output logic [31:0] mtval_out,
    output logic        trap_flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        stall_out,
    output logic        in_mret
);

    localparam logic [31:0]      CAUSE_ILLEGAL = 32'd2;
    localparam logic [31:0]      CAUSE_ECALL_M = 32'd11;
    localparam logic [CNT_W-1:0] DRAIN_LOAD    = CNT_W'(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_REDIRECT,
        S_DRAIN
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             csr_we_d, trap_flush_d, redirect_valid_d, stall_d, in_mret_d;
    logic [31:0]      mcause_d, mepc_d, mtval_d, redirect_pc_d;

    // The trap vector and the return address are word aligned, so their low
    // two bits are never used.
    logic unused_low_bits;
    assign unused_low_bits = ^{mtvec_in[1:0], mepc_in[1:0]};

    // A decode-slot event is taken only from a real, unstalled, right-path instruction.
    logic sample_ok;
    logic any_event;
    assign sample_ok = id_valid && !stall_mmu && !flush_in;
    assign any_event = invalid_inst || ecall || mret;

    // Next-state and next-output logic; registered values are computed here.
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        csr_we_d         = 1'b0;
        trap_flush_d     = 1'b0;
        redirect_valid_d = redirect_valid;
        redirect_pc_d    = redirect_pc;
        stall_d          = stall_out;
        in_mret_d        = in_mret;
        mcause_d         = mcause_out;
        mepc_d           = mepc_out;
        mtval_d          = mtval_out;

        unique case (state_q)
            S_IDLE: begin
                if (sample_ok && any_event) begin
                    state_d = S_WRITE;
                    stall_d = 1'b1;
                    if (invalid_inst) begin
                        mcause_d      = CAUSE_ILLEGAL;
                        mepc_d        = id_pc;
                        mtval_d       = faulting_inst;
                        redirect_pc_d = {mtvec_in[31:2], 2'b00};
                        in_mret_d     = 1'b0;
                    end else if (ecall) begin
                        mcause_d      = CAUSE_ECALL_M;
                        mepc_d        = id_pc;
                        mtval_d       = 32'd0;
                        redirect_pc_d = {mtvec_in[31:2], 2'b00};
                        in_mret_d     = 1'b0;
                    end else begin
                        // MRET leaves the trap CSR values untouched.
                        redirect_pc_d = {mepc_in[31:2], 2'b00};
                        in_mret_d     = 1'b1;
                    end
                end
            end

            S_WRITE: begin
                if (!stall_mmu) begin
                    trap_flush_d     = 1'b1;
                    csr_we_d         = !in_mret;
                    redirect_valid_d = 1'b1;
                    state_d          = S_REDIRECT;
                end
            end

            S_REDIRECT: begin
                if (redirect_valid && redirect_ready && !stall_mmu) begin
                    redirect_valid_d = 1'b0;
                    cnt_d            = DRAIN_LOAD;
                    state_d          = S_DRAIN;
                end
            end

            S_DRAIN: begin
                if (!stall_mmu) begin
                    if (cnt_q <= CNT_ONE) begin
                        cnt_d     = '0;
                        stall_d   = 1'b0;
                        in_mret_d = 1'b0;
                        state_d   = S_IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset clears everything, including the CSR payload.
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            csr_we         <= 1'b0;
            trap_flush     <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'd0;
            stall_out      <= 1'b0;
            in_mret        <= 1'b0;
            mcause_out     <= 32'd0;
            mepc_out       <= 32'd0;
            mtval_out      <= 32'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            csr_we         <= csr_we_d;
            trap_flush     <= trap_flush_d;
            redirect_valid <= redirect_valid_d;
            redirect_pc    <= redirect_pc_d;
            stall_out      <= stall_d;
            in_mret        <= in_mret_d;
            mcause_out     <= mcause_d;
            mepc_out       <= mepc_d;
            mtval_out      <= mtval_d;
        end
    end

endmodule

// File: tb/tb_trap_controller.sv
// Directed self-checking bench for trap_controller (DRAIN_CYCLES=4).
module tb_trap_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_pc;
    logic        invalid_inst;
    logic        ecall;
    logic        mret;
    logic [31:0] faulting_inst;
    logic        flush_in;
    logic        stall_mmu;
    logic [31:0] mtvec_in;
    logic [31:0] mepc_in;
    logic        redirect_ready;
    logic        csr_we;
    logic [31:0] mcause_out;
    logic [31:0] mepc_out;
    logic [31:0] mtval_out;
    logic        trap_flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall_out;
    logic        in_mret;

    int n_checks = 0;
    int n_errors = 0;

    // Per-sequence observations gathered by run_seq.
    int          seq_stall, seq_csr, seq_flush, seq_rv;
    int          first_csr, first_rv;
    logic        pc_stable;
    logic        mret_at_start;
    logic [31:0] cap_pc, cap_mcause, cap_mepc, cap_mtval;

    trap_controller #(.DRAIN_CYCLES(4), .CNT_W(3)) dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .invalid_inst   (invalid_inst),
        .ecall          (ecall),
        .mret           (mret),
        .faulting_inst  (faulting_inst),
        .flush_in       (flush_in),
        .stall_mmu      (stall_mmu),
        .mtvec_in       (mtvec_in),
        .mepc_in        (mepc_in),
        .redirect_ready (redirect_ready),
        .csr_we         (csr_we),
        .mcause_out     (mcause_out),
        .mepc_out       (mepc_out),
        .mtval_out      (mtval_out),
        .trap_flush     (trap_flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall_out      (stall_out),
        .in_mret        (in_mret)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge and sample 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one decode-slot event for a single edge, then return the slot to a bubble.
    task automatic fire(input logic inv, input logic ec, input logic mr,
                        input logic [31:0] pc, input logic [31:0] inst, input logic fl);
        id_valid      = 1'b1;
        invalid_inst  = inv;
        ecall         = ec;
        mret          = mr;
        id_pc         = pc;
        faulting_inst = inst;
        flush_in      = fl;
        step();
        id_valid      = 1'b0;
        invalid_inst  = 1'b0;
        ecall         = 1'b0;
        mret          = 1'b0;
        flush_in      = 1'b0;
    endtask

    // Called right after the event edge. Walks the sequence until stall_out drops.
    // It holds stall_mmu for the first mmu_n cycles and withholds redirect_ready
    // for ready_delay cycles of redirect_valid.
    task automatic run_seq(input int ready_delay, input int mmu_n);
        int k;
        seq_stall = 0; seq_csr = 0; seq_flush = 0; seq_rv = 0;
        first_csr = -1; first_rv = -1; pc_stable = 1'b1;
        cap_pc = 32'd0; cap_mcause = 32'd0; cap_mepc = 32'd0; cap_mtval = 32'd0;
        mret_at_start = in_mret;
        k = 0;
        while (stall_out && k < 40) begin
            seq_stall++;
            if (csr_we) begin
                if (first_csr < 0) first_csr = k;
                seq_csr++;
            end
            if (first_csr == k) begin
                cap_mcause = mcause_out;
                cap_mepc   = mepc_out;
                cap_mtval  = mtval_out;
            end
            if (trap_flush) seq_flush++;
            if (redirect_valid) begin
                if (seq_rv == 0) begin
                    first_rv = k;
                    cap_pc   = redirect_pc;
                end else if (redirect_pc !== cap_pc) begin
                    pc_stable = 1'b0;
                end
                seq_rv++;
            end
            stall_mmu      = (k < mmu_n);
            redirect_ready = (seq_rv > ready_delay);
            step();
            k++;
        end
        stall_mmu      = 1'b0;
        redirect_ready = 1'b0;
        check("seq_done_in_budget", {31'd0, stall_out}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; id_valid = 1'b0; id_pc = 32'd0; invalid_inst = 1'b0; ecall = 1'b0;
        mret = 1'b0; faulting_inst = 32'd0; flush_in = 1'b0; stall_mmu = 1'b0;
        mtvec_in = 32'h8000_0001; mepc_in = 32'h0000_0204; redirect_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        step();

        // Reset state
        check("rst_flags", {27'd0, csr_we, trap_flush, redirect_valid, stall_out, in_mret}, 32'd0);
        check("rst_mcause", mcause_out, 32'd0);
        check("rst_redirect_pc", redirect_pc, 32'd0);

        // Illegal instruction trap
        fire(1'b1, 1'b0, 1'b0, 32'h100, 32'hFFFF_FFFF, 1'b0);
        check("ill_stall_first", {31'd0, stall_out}, 32'd1);
        check("ill_csr_we_not_yet", {31'd0, csr_we}, 32'd0);
        run_seq(0, 0);
        check("ill_stall_cycles", seq_stall, 6);
        check("ill_csr_pulses", seq_csr, 1);
        check("ill_flush_pulses", seq_flush, 1);
        check("ill_csr_cycle", first_csr, 1);
        check("ill_rv_cycles", seq_rv, 1);
        check("ill_mcause", cap_mcause, 32'd2);
        check("ill_mepc", cap_mepc, 32'h100);
        check("ill_mtval", cap_mtval, 32'hFFFF_FFFF);
        check("ill_redirect_pc", cap_pc, 32'h8000_0000);
        check("ill_in_mret", {31'd0, mret_at_start}, 32'd0);

        // ECALL
        fire(1'b0, 1'b1, 1'b0, 32'h204, 32'h0000_0073, 1'b0);
        run_seq(0, 0);
        check("ecall_mcause", cap_mcause, 32'd11);
        check("ecall_mepc", cap_mepc, 32'h204);
        check("ecall_mtval", cap_mtval, 32'd0);
        check("ecall_csr_pulses", seq_csr, 1);
        check("ecall_stall_cycles", seq_stall, 6);

        // MRET: no CSR write, redirect to mepc, trap CSR values retained
        fire(1'b0, 1'b0, 1'b1, 32'h400, 32'h3020_0073, 1'b0);
        check("mret_flag", {31'd0, in_mret}, 32'd1);
        run_seq(0, 0);
        check("mret_csr_pulses", seq_csr, 0);
        check("mret_flush_pulses", seq_flush, 1);
        check("mret_redirect_pc", cap_pc, 32'h204);
        check("mret_flag_cleared", {31'd0, in_mret}, 32'd0);
        check("mret_keeps_mcause", mcause_out, 32'd11);

        // Redirect held for 3 cycles without ready
        fire(1'b0, 1'b1, 1'b0, 32'h500, 32'd0, 1'b0);
        run_seq(3, 0);
        check("hs_rv_cycles", seq_rv, 4);
        check("hs_pc_stable", {31'd0, pc_stable}, 32'd1);
        check("hs_stall_cycles", seq_stall, 9);

        // MMU stall for 2 cycles while in WRITE
        fire(1'b0, 1'b1, 1'b0, 32'h600, 32'd0, 1'b0);
        run_seq(0, 2);
        check("mmu_csr_pulses", seq_csr, 1);
        check("mmu_csr_cycle", first_csr, 3);
        check("mmu_first_rv", first_rv, 3);
        check("mmu_stall_cycles", seq_stall, 8);

        // ECALL with a same-cycle flush is discarded
        fire(1'b0, 1'b1, 1'b0, 32'h700, 32'd0, 1'b1);
        check("flush_no_stall", {31'd0, stall_out}, 32'd0);
        step();
        check("flush_no_strobe", {30'd0, csr_we, trap_flush}, 32'd0);
        check("flush_mepc_kept", mepc_out, 32'h600);

        // Bubble slot (id_valid=0) carries no event
        id_valid = 1'b0; ecall = 1'b1;
        step();
        ecall = 1'b0;
        check("bubble_no_stall", {31'd0, stall_out}, 32'd0);

        // Illegal and ECALL together: illegal wins
        fire(1'b1, 1'b1, 1'b0, 32'h800, 32'h1234_5678, 1'b0);
        run_seq(0, 0);
        check("prio_mcause", cap_mcause, 32'd2);
        check("prio_mtval", cap_mtval, 32'h1234_5678);

        // Reset during REDIRECT
        fire(1'b0, 1'b1, 1'b0, 32'h900, 32'd0, 1'b0);
        step();
        check("pre_rst_rv", {31'd0, redirect_valid}, 32'd1);
        step();
        rst = 1'b1;
        step();
        check("mid_rst_flags", {27'd0, csr_we, trap_flush, redirect_valid, stall_out, in_mret}, 32'd0);
        check("mid_rst_mcause", mcause_out, 32'd0);
        check("mid_rst_mepc", mepc_out, 32'd0);
        check("mid_rst_redirect_pc", redirect_pc, 32'd0);
        rst = 1'b0;
        step();
        check("post_rst_quiet", {30'd0, csr_we, stall_out}, 32'd0);
        fire(1'b0, 1'b1, 1'b0, 32'hA00, 32'd0, 1'b0);
        run_seq(0, 0);
        check("post_rst_mcause", cap_mcause, 32'd11);
        check("post_rst_mepc", cap_mepc, 32'hA00);
        check("post_rst_stall_cycles", seq_stall, 6);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
